// File: rtl/instr_sequencer.sv
// Program sequencer: fetches instructions from a 1-cycle-latency BRAM and hands
// each one to the DSP instruction controller over the start/valid handshake.
module instr_sequencer #(
  parameter int I_WIDTH  = 32,
  parameter int PC_WIDTH = 6,
  parameter int TIMEOUT  = 63
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                run_i,
  input  logic [PC_WIDTH-1:0] prog_len_i,
  output logic                imem_en_o,
  output logic [PC_WIDTH-1:0] imem_addr_o,
  input  logic [I_WIDTH-1:0]  imem_data_i,
  output logic                ctrl_start_o,
  output logic [I_WIDTH-1:0]  ctrl_instr_o,
  input  logic                ctrl_valid_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                timeout_o,
  output logic [PC_WIDTH-1:0] pc_o
);

  // state   | meaning
  // IDLE    | waiting for a run_i rising edge, pc held at 0
  // FETCH   | BRAM read of imem[pc]
  // LOAD    | BRAM data returns, captured into ctrl_instr_o
  // ISSUE   | start high, waiting for controller valid
  // RELEASE | start low, waiting for controller valid to drop
  // DONE    | program complete, waiting for run_i low
  // ERROR   | handshake timed out, waiting for run_i low
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_ISSUE, S_RELEASE, S_DONE, S_ERROR
  } state_t;

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t              state_q, state_n;
  logic                run_q;
  logic                abort_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] len_q;
  logic [TW-1:0]       tmo_q;
  logic                tmo_hit;
  logic                last_instr;

  // The wait expires on the edge that would bring the count to TIMEOUT, so the
  // error state is entered exactly TIMEOUT cycles after the wait began.
  assign tmo_hit    = (tmo_q == TW'(TIMEOUT - 1));
  assign last_instr = (pc_q == len_q - PC_WIDTH'(1));

  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE:
        if (run_i && !run_q) state_n = (prog_len_i == '0) ? S_DONE : S_FETCH;
      S_FETCH:
        state_n = run_i ? S_LOAD : S_IDLE;
      S_LOAD:
        state_n = run_i ? S_ISSUE : S_IDLE;
      S_ISSUE:
        if (ctrl_valid_i)  state_n = S_RELEASE;
        else if (tmo_hit)  state_n = S_ERROR;
      S_RELEASE:
        if (!ctrl_valid_i) begin
          if (abort_q || !run_i) state_n = S_IDLE;
          else if (last_instr)   state_n = S_DONE;
          else                   state_n = S_FETCH;
        end else if (tmo_hit) begin
          state_n = S_ERROR;
        end
      S_DONE, S_ERROR:
        if (!run_i) state_n = S_IDLE;
      default:
        state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      run_q        <= 1'b0;
      abort_q      <= 1'b0;
      pc_q         <= '0;
      len_q        <= '0;
      tmo_q        <= '0;
      ctrl_instr_o <= '0;
      imem_en_o    <= 1'b0;
      ctrl_start_o <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      timeout_o    <= 1'b0;
    end else begin
      state_q <= state_n;
      run_q   <= run_i;

      if (state_q == S_IDLE && state_n != S_IDLE) len_q <= prog_len_i;

      if (state_n == S_IDLE)
        pc_q <= '0;
      else if (state_q == S_RELEASE && state_n == S_FETCH)
        pc_q <= pc_q + PC_WIDTH'(1);

      // A drop of run_i mid-handshake is remembered so the handshake can finish.
      if (state_n == S_IDLE)
        abort_q <= 1'b0;
      else if ((state_q == S_ISSUE || state_q == S_RELEASE) && !run_i)
        abort_q <= 1'b1;

      if ((state_n == S_ISSUE && state_q != S_ISSUE) ||
          (state_n == S_RELEASE && state_q != S_RELEASE))
        tmo_q <= '0;
      else if ((state_q == S_ISSUE || state_q == S_RELEASE) && tmo_q < TW'(TIMEOUT))
        tmo_q <= tmo_q + TW'(1);

      if (state_q == S_LOAD) ctrl_instr_o <= imem_data_i;

      imem_en_o    <= (state_n == S_FETCH);
      ctrl_start_o <= (state_n == S_ISSUE);
      busy_o       <= !(state_n == S_IDLE || state_n == S_DONE || state_n == S_ERROR);
      done_o       <= (state_n == S_DONE);
      timeout_o    <= (state_n == S_ERROR);
    end
  end

  assign imem_addr_o = pc_q;
  assign pc_o        = pc_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: BRAM model, controller model and a
// scoreboard that checks every issued instruction against a queue of expectations.
module tb_instr_sequencer;
  localparam int IW  = 32;
  localparam int PW  = 6;
  localparam int TMO = 63;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          run_i = 1'b0;
  logic [PW-1:0] prog_len_i = '0;
  logic          imem_en_o;
  logic [PW-1:0] imem_addr_o;
  logic [IW-1:0] imem_data_i;
  logic          ctrl_start_o;
  logic [IW-1:0] ctrl_instr_o;
  logic          ctrl_valid_i;
  logic          busy_o, done_o, timeout_o;
  logic [PW-1:0] pc_o;

  int checks = 0;
  int failures = 0;
  int n_fetch = 0;
  int n_starts = 0;
  logic [IW-1:0] mem [0:63];
  logic [IW-1:0] exp_q [$];
  logic [IW-1:0] cur_exp = '0;
  logic          prev_start = 1'b0;
  logic          ctl_hang = 1'b0;
  int            ctl_cnt = 0;

  instr_sequencer #(.I_WIDTH(IW), .PC_WIDTH(PW), .TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .run_i(run_i), .prog_len_i(prog_len_i),
    .imem_en_o(imem_en_o), .imem_addr_o(imem_addr_o), .imem_data_i(imem_data_i),
    .ctrl_start_o(ctrl_start_o), .ctrl_instr_o(ctrl_instr_o), .ctrl_valid_i(ctrl_valid_i),
    .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o), .pc_o(pc_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // BRAM with one cycle of read latency
  always @(posedge clk_i) begin
    if (imem_en_o) imem_data_i <= mem[imem_addr_o];
    if (rst_ni && imem_en_o) n_fetch++;
  end

  // Controller: raises valid three cycles into start, drops it once start falls
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_valid_i <= 1'b0;
      ctl_cnt      <= 0;
    end else if (!ctl_hang) begin
      if (ctrl_start_o && !ctrl_valid_i) begin
        if (ctl_cnt == 2) begin
          ctrl_valid_i <= 1'b1;
          ctl_cnt      <= 0;
        end else begin
          ctl_cnt <= ctl_cnt + 1;
        end
      end else if (!ctrl_start_o && ctrl_valid_i) begin
        ctrl_valid_i <= 1'b0;
      end
    end
  end

  // Scoreboard monitor: pops one expectation per start pulse, checks stability
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (ctrl_start_o && !prev_start) begin
        n_starts++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_start: instr 0x%0h with empty queue at %0t", ctrl_instr_o, $time);
        end else begin
          cur_exp = exp_q.pop_front();
          chk("instr_at_start", ctrl_instr_o, cur_exp);
        end
      end else if (ctrl_start_o) begin
        chk("instr_stable", ctrl_instr_o, cur_exp);
      end
    end
    prev_start = ctrl_start_o & rst_ni;
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_i);
  endtask

  task automatic wait_done(input string name);
    int i;
    i = 0;
    while (!done_o && i < 1000) begin
      @(negedge clk_i);
      i++;
    end
    chk(name, done_o, 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_start"}, ctrl_start_o, 0);
    chk({tag, "_en"}, imem_en_o, 0);
    chk({tag, "_addr"}, imem_addr_o, 0);
    chk({tag, "_instr"}, ctrl_instr_o, 0);
    chk({tag, "_pc"}, pc_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_timeout"}, timeout_o, 0);
  endtask

  initial begin
    int f0, s0, n;
    for (int i = 0; i < 64; i++) mem[i] = 32'hDEAD_0000 | i;
    mem[0] = 32'hA000_0001;
    mem[1] = 32'hA000_0002;
    mem[2] = 32'hA000_0003;

    #1;
    check_all_zero("reset");
    cycles(2);
    rst_ni = 1'b1;
    cycles(2);

    // Reset asserted while the first instruction is being issued
    prog_len_i = 6'd3;
    exp_q.push_back(mem[0]);
    run_i = 1'b1;
    n = 0;
    while (!ctrl_start_o && n < 50) begin @(negedge clk_i); n++; end
    chk("rst_reach_issue", ctrl_start_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    check_all_zero("rst_mid_issue");
    chk("rst_ctl_valid", ctrl_valid_i, 0);
    exp_q.delete();
    run_i = 1'b0;
    cycles(2);
    rst_ni = 1'b1;
    cycles(2);

    // Three-instruction program
    f0 = n_fetch; s0 = n_starts;
    for (int i = 0; i < 3; i++) exp_q.push_back(mem[i]);
    prog_len_i = 6'd3;
    run_i = 1'b1;
    wait_done("prog3_done");
    chk("prog3_pc", pc_o, 2);
    chk("prog3_starts", n_starts - s0, 3);
    chk("prog3_fetches", n_fetch - f0, 3);
    chk("prog3_busy", busy_o, 0);
    run_i = 1'b0;
    cycles(2);
    chk("prog3_done_clear", done_o, 0);
    chk("prog3_pc_clear", pc_o, 0);

    // Zero-length program
    f0 = n_fetch; s0 = n_starts;
    prog_len_i = 6'd0;
    run_i = 1'b1;
    cycles(2);
    chk("len0_done", done_o, 1);
    cycles(3);
    chk("len0_fetches", n_fetch - f0, 0);
    chk("len0_starts", n_starts - s0, 0);
    run_i = 1'b0;
    cycles(2);

    // Controller never answers
    ctl_hang = 1'b1;
    exp_q.push_back(mem[0]);
    prog_len_i = 6'd1;
    run_i = 1'b1;
    n = 0;
    while (!ctrl_start_o && n < 50) begin @(negedge clk_i); n++; end
    chk("tmo_reach_issue", ctrl_start_o, 1);
    n = 0;
    while (!timeout_o && n < 200) begin @(negedge clk_i); n++; end
    chk("tmo_latency", n, TMO);
    chk("tmo_start_low", ctrl_start_o, 0);
    chk("tmo_busy", busy_o, 0);
    cycles(3);
    chk("tmo_held", timeout_o, 1);
    run_i = 1'b0;
    cycles(2);
    chk("tmo_clear", timeout_o, 0);
    chk("tmo_idle_busy", busy_o, 0);
    ctl_hang = 1'b0;
    cycles(2);

    // Abort during the second ISSUE of a five-instruction program
    for (int i = 0; i < 5; i++) mem[i] = 32'hB000_0001 + i;
    f0 = n_fetch; s0 = n_starts;
    exp_q.push_back(mem[0]);
    exp_q.push_back(mem[1]);
    prog_len_i = 6'd5;
    run_i = 1'b1;
    n = 0;
    while (n_starts - s0 < 2 && n < 200) begin @(negedge clk_i); n++; end
    chk("abort_reach_2nd", n_starts - s0, 2);
    run_i = 1'b0;
    n = 0;
    while (busy_o && n < 200) begin @(negedge clk_i); n++; end
    chk("abort_idle", busy_o, 0);
    cycles(5);
    chk("abort_done", done_o, 0);
    chk("abort_fetches", n_fetch - f0, 2);
    chk("abort_starts", n_starts - s0, 2);
    chk("abort_ctl_valid", ctrl_valid_i, 0);

    // run_i held high after DONE must not restart; a fresh edge does
    mem[0] = 32'hC000_0001;
    mem[1] = 32'hC000_0002;
    exp_q.push_back(mem[0]);
    exp_q.push_back(mem[1]);
    f0 = n_fetch;
    prog_len_i = 6'd2;
    run_i = 1'b1;
    wait_done("hold_done");
    cycles(20);
    chk("hold_no_refetch", n_fetch - f0, 2);
    chk("hold_still_done", done_o, 1);
    chk("hold_pc", pc_o, 1);
    exp_q.push_back(mem[0]);
    exp_q.push_back(mem[1]);
    run_i = 1'b0;
    cycles(1);
    run_i = 1'b1;
    n = 0;
    while (!imem_en_o && n < 20) begin @(negedge clk_i); n++; end
    chk("restart_fetch", imem_en_o, 1);
    chk("restart_addr", imem_addr_o, 0);
    chk("restart_pc", pc_o, 0);
    wait_done("restart_done");
    chk("restart_fetches", n_fetch - f0, 4);
    run_i = 1'b0;
    cycles(2);

    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Program sequencer that drives the DSP instruction controller. It fetches instructions in order from an instruction BRAM with 1-cycle read latency, presents each one to the controller through the start/valid handshake, and waits for completion before fetching the next. It sits between the top-level run control and the controller, and is the only master of the controller's start_i and instruction_i.

Parameters:
I_WIDTH, 32, instruction width; equals `I_WIDTH in def.v.
PC_WIDTH, 6, program counter / instruction memory address width.
TIMEOUT, 63, maximum cycles to wait in ISSUE or RELEASE before flagging an error.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
run_i  in  1  level; rising edge in IDLE starts a program; deassertion aborts
prog_len_i  in  PC_WIDTH  instruction count; sampled when leaving IDLE
imem_en_o  out  1  instruction BRAM read enable
imem_addr_o  out  PC_WIDTH  instruction BRAM read address
imem_data_i  in  I_WIDTH  BRAM read data, valid the cycle after imem_en_o
ctrl_start_o  out  1  connects to controller start_i
ctrl_instr_o  out  I_WIDTH  connects to controller instruction_i
ctrl_valid_i  in  1  connects to controller valid_o
busy_o  out  1  high in every state except IDLE, DONE and ERROR
done_o  out  1  program completed; held until run_i is low
timeout_o  out  1  handshake timeout; held until run_i is low
pc_o  out  PC_WIDTH  index of the current instruction

Behaviour:
- Reset (asynchronous, active-low): state=IDLE. All outputs are 0, including pc, ctrl_instr_o, the latched length, the abort flag and the timeout counter.
- All outputs are registered or decoded from state only. There is no combinational path from an input to an output.
- IDLE: pc=0. If run_i=1: latch prog_len_i. If it is 0, go to DONE; otherwise go to FETCH.
- FETCH (1 cycle): imem_en_o=1, imem_addr_o=pc. Next state is LOAD.
- LOAD (1 cycle): capture imem_data_i into ctrl_instr_o at the end of the cycle. Next state is ISSUE.
- ISSUE: ctrl_start_o=1.
  - ctrl_instr_o stays stable from ISSUE entry until RELEASE exit, because the controller samples it in its DECODE state.
  - On ctrl_valid_i=1, go to RELEASE.
- RELEASE: ctrl_start_o=0. Wait for ctrl_valid_i=0, which means the controller has returned to IDLE. Then:
  - if the abort flag is set, go to IDLE;
  - else if pc==len-1, go to DONE;
  - else pc<=pc+1 and go to FETCH.
- DONE: done_o=1. Leave for IDLE when run_i=0.
- ERROR: timeout_o=1, ctrl_start_o=0. Leave for IDLE when run_i=0.
- Timeout:
  - The counter clears on entry to ISSUE and on entry to RELEASE, and increments every cycle in those states.
  - When it reaches TIMEOUT and the wait condition is still unmet, go to ERROR.
  - It is a saturating count; it never wraps.
- Abort: run_i=0 during FETCH or LOAD goes to IDLE next cycle with no controller handshake. run_i=0 during ISSUE or RELEASE sets the abort flag; the current handshake completes normally, then the block returns to IDLE. The flag clears in IDLE.
- pc width: pc never exceeds len-1, so no wrap occurs. len=2^PC_WIDTH-1 is legal.
- A run_i that stays high after DONE does not restart the program. run_i must return low first.
- Simultaneous events: ctrl_valid_i=1 and timeout expiry in the same ISSUE cycle resolve to RELEASE; valid wins.
- Minimum per-instruction overhead is FETCH + LOAD + one RELEASE cycle = 3 cycles, plus the controller's own latency.

Test Plan:
- Reset mid-ISSUE: assert rst_ni=0 -> all outputs 0 and state=IDLE immediately (asynchronous); controller model sees start low.
- prog_len_i=3, imem words 0xA0000001/0xA0000002/0xA0000003, real controller -> three start pulses. Each ctrl_instr_o matches its word and is stable while start is high. done_o=1 after the third valid falls; pc_o ends at 2.
- prog_len_i=0, run_i=1 -> done_o=1 two cycles later. imem_en_o and ctrl_start_o never assert.
- Controller model that never raises valid -> timeout_o=1 exactly TIMEOUT cycles after ISSUE entry; ctrl_start_o=0; run_i=0 then returns to IDLE.
- run_i dropped during the 2nd ISSUE of a 5-instruction program -> the 2nd instruction completes, there is no 3rd fetch, the block ends in IDLE and done_o stays 0.
- After DONE with run_i held high for 20 cycles -> no new fetch. Toggle run_i 0→1 -> the program restarts from pc=0.
